// File: rtl/memory_access_arbiter.sv
// Sequencer and two-requester arbiter for a 1K x 8 dual-port memory tile.
// Clears the memory after reset, then round-robins the write and read ports independently.
module memory_access_arbiter #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 8,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        req_ready,
    output logic [1:0]        resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              init_done
);

    // Handshake: a request transfers in any cycle where req_valid[i] and
    // req_ready[i] are both 1; requesters hold req_* stable until then.

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              rsp_pend;
    logic              rsp_id;

    logic              run;
    logic              sweep;
    logic [1:0]        wr_cand;
    logic [1:0]        rd_cand;
    logic [1:0]        wr_gnt;
    logic [1:0]        rd_sel;
    logic [1:0]        rd_gnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              hazard;

    always_comb begin
        run     = (state == ST_RUN);
        wr_cand = run ? (req_valid & req_we)  : 2'b00;
        rd_cand = run ? (req_valid & ~req_we) : 2'b00;

        // With both candidates present the pointer picks; otherwise the lone one wins.
        wr_gnt  = (wr_cand == 2'b11) ? (wr_ptr ? 2'b10 : 2'b01) : wr_cand;
        rd_sel  = (rd_cand == 2'b11) ? (rd_ptr ? 2'b10 : 2'b01) : rd_cand;

        wr_addr = wr_gnt[1] ? req_addr1  : req_addr0;
        wr_data = wr_gnt[1] ? req_wdata1 : req_wdata0;
        rd_addr = rd_sel[1] ? req_addr1  : req_addr0;

        // A read colliding with this cycle's write would see stale data; hold it one cycle.
        hazard  = (wr_gnt != 2'b00) && (rd_sel != 2'b00) && (rd_addr == wr_addr);
        rd_gnt  = hazard ? 2'b00 : rd_sel;

        // The clear sweep is masked while reset is high so every output reads 0 in reset.
        sweep   = (state == ST_INIT) && INIT_ON_RESET && !reset;
    end

    always_comb begin
        req_ready   = wr_gnt | rd_gnt;
        mem_wen     = 1'b0;
        mem_waddr   = '0;
        mem_data_in = '0;
        if (sweep) begin
            mem_wen   = 1'b1;
            mem_waddr = clr_cnt;
        end else if (wr_gnt != 2'b00) begin
            mem_wen     = 1'b1;
            mem_waddr   = wr_addr;
            mem_data_in = wr_data;
        end
        mem_ren    = (rd_gnt != 2'b00);
        mem_raddr  = mem_ren ? rd_addr : '0;
        resp_valid = rsp_pend ? (rsp_id ? 2'b10 : 2'b01) : 2'b00;
        resp_rdata = rsp_pend ? mem_data_out : '0;
        init_done  = run;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            clr_cnt  <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            rsp_pend <= 1'b0;
            rsp_id   <= 1'b0;
        end else begin
            rsp_pend <= (rd_gnt != 2'b00);
            rsp_id   <= rd_gnt[1];
            case (state)
                ST_INIT: begin
                    if (!INIT_ON_RESET || (&clr_cnt)) begin
                        state <= ST_RUN;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    // After a grant the pointer names the requester that lost.
                    if (wr_gnt != 2'b00) begin
                        wr_ptr <= wr_gnt[0];
                    end
                    if (rd_gnt != 2'b00) begin
                        rd_ptr <= rd_gnt[0];
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Directed bench for memory_access_arbiter with a behavioural 1K x 8 synchronous-read memory.
// Read responses are checked by a queue-based monitor; grants and memory pins per cycle.
module tb_memory_access_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int EW     = 26;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        req_valid;
    logic [1:0]        req_we;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        req_ready;
    logic [1:0]        resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_raddr;
    logic              mem_ren;
    logic [DATA_W-1:0] mem_data_out;
    logic              init_done;

    memory_access_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .INIT_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_we(req_we),
        .req_addr0(req_addr0),
        .req_addr1(req_addr1),
        .req_wdata0(req_wdata0),
        .req_wdata1(req_wdata1),
        .req_ready(req_ready),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .mem_waddr(mem_waddr),
        .mem_data_in(mem_data_in),
        .mem_wen(mem_wen),
        .mem_raddr(mem_raddr),
        .mem_ren(mem_ren),
        .mem_data_out(mem_data_out),
        .init_done(init_done)
    );

    // ---------------- clock / reset / memory model ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= mem_data_in;
        if (mem_ren) mem_data_out <= mem[mem_raddr];
    end

    logic [42:0] all_out;
    assign all_out = {req_ready, resp_valid, resp_rdata, mem_waddr, mem_data_in,
                      mem_wen, mem_raddr, mem_ren, init_done};

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response is popped against {cycle, resp_valid, data}.
    always @(negedge clk) begin
        if (resp_valid !== 2'b00) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got valid %b data %0h, expected no response (cycle %0d)",
                         resp_valid, resp_rdata, cyc);
            end else begin
                exp_e = exp_q.pop_front();
                check("resp", {cyc[15:0], resp_valid, resp_rdata}, exp_e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                         input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
        req_valid  = v;
        req_we     = we;
        req_addr0  = a0;
        req_addr1  = a1;
        req_wdata0 = d0;
        req_wdata1 = d1;
    endtask

    // Checks one cycle's grant and memory pins, and queues the read response expected next cycle.
    task automatic expect_cycle(input string name, input logic [1:0] rdy,
                                input logic wen, input logic [ADDR_W-1:0] waddr,
                                input logic [DATA_W-1:0] wdata,
                                input logic ren, input logic [ADDR_W-1:0] raddr,
                                input logic [1:0] rsp_v, input logic [DATA_W-1:0] rsp_d);
        logic [15:0] next_cyc;
        @(negedge clk);
        check(name, {req_ready, mem_wen, mem_waddr, mem_data_in, mem_ren, mem_raddr},
                    {rdy, wen, waddr, wdata, ren, raddr});
        if (rsp_v != 2'b00) begin
            next_cyc = cyc[15:0] + 16'd1;
            exp_q.push_back({next_cyc, rsp_v, rsp_d});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        drive(2'b11, 2'b11, 10'd5, 10'd9, 8'h11, 8'h22);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_out, 43'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Clear sweep with both requesters asking to write throughout.
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            check("init_sweep", {init_done, mem_wen, mem_waddr, mem_data_in, req_ready},
                                {1'b0, 1'b1, i[9:0], 8'h00, 2'b00});
            @(posedge clk);
        end
        #1;
        check("init_done", init_done, 1'b1);

        // Write contention: alternate starting with requester 0.
        expect_cycle("wr_arb_0a", 2'b01, 1'b1, 10'd5, 8'h11, 1'b0, 10'd0, 2'b00, 8'h00);
        expect_cycle("wr_arb_1a", 2'b10, 1'b1, 10'd9, 8'h22, 1'b0, 10'd0, 2'b00, 8'h00);
        expect_cycle("wr_arb_0b", 2'b01, 1'b1, 10'd5, 8'h11, 1'b0, 10'd0, 2'b00, 8'h00);
        expect_cycle("wr_arb_1b", 2'b10, 1'b1, 10'd9, 8'h22, 1'b0, 10'd0, 2'b00, 8'h00);

        // Read contention: requester 0 reads addr 9, requester 1 reads addr 5.
        drive(2'b11, 2'b00, 10'd9, 10'd5, 8'h00, 8'h00);
        expect_cycle("rd_arb_0a", 2'b01, 1'b0, 10'd0, 8'h00, 1'b1, 10'd9, 2'b01, 8'h22);
        expect_cycle("rd_arb_1a", 2'b10, 1'b0, 10'd0, 8'h00, 1'b1, 10'd5, 2'b10, 8'h11);
        expect_cycle("rd_arb_0b", 2'b01, 1'b0, 10'd0, 8'h00, 1'b1, 10'd9, 2'b01, 8'h22);
        expect_cycle("rd_arb_1b", 2'b10, 1'b0, 10'd0, 8'h00, 1'b1, 10'd5, 2'b10, 8'h11);

        // Parallel ports: pre-write addr 7, then write addr 3 while reading addr 7.
        drive(2'b01, 2'b01, 10'd7, 10'd0, 8'h3C, 8'h00);
        expect_cycle("prewrite", 2'b01, 1'b1, 10'd7, 8'h3C, 1'b0, 10'd0, 2'b00, 8'h00);
        drive(2'b11, 2'b01, 10'd3, 10'd7, 8'hA5, 8'h00);
        expect_cycle("parallel", 2'b11, 1'b1, 10'd3, 8'hA5, 1'b1, 10'd7, 2'b10, 8'h3C);

        // Hazard: same-address read is held off one cycle and returns the new data.
        drive(2'b11, 2'b01, 10'd12, 10'd12, 8'h55, 8'h00);
        expect_cycle("hazard_block", 2'b01, 1'b1, 10'd12, 8'h55, 1'b0, 10'd0, 2'b00, 8'h00);
        drive(2'b10, 2'b01, 10'd12, 10'd12, 8'h55, 8'h00);
        expect_cycle("hazard_retry", 2'b10, 1'b0, 10'd0, 8'h00, 1'b1, 10'd12, 2'b10, 8'h55);

        drive(2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00);
        expect_cycle("idle", 2'b00, 1'b0, 10'd0, 8'h00, 1'b0, 10'd0, 2'b00, 8'h00);
        drive(2'b01, 2'b00, 10'd3, 10'd0, 8'h00, 8'h00);
        expect_cycle("readback", 2'b01, 1'b0, 10'd0, 8'h00, 1'b1, 10'd3, 2'b01, 8'hA5);

        // Reset in the cycle after a read grant: no response, outputs clear, sweep restarts.
        drive(2'b10, 2'b00, 10'd0, 10'd5, 8'h00, 8'h00);
        @(negedge clk);
        check("rst_rd_grant", {req_ready, mem_ren, mem_raddr}, {2'b10, 1'b1, 10'd5});
        @(posedge clk);
        #1 reset = 1'b1;
        drive(2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00);
        @(negedge clk);
        check("reset_mid_read", all_out, 43'd0);
        @(posedge clk);
        @(negedge clk);
        check("reset_held", all_out, 43'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reinit_addr0", {init_done, mem_wen, mem_waddr, mem_data_in, req_ready},
                              {1'b0, 1'b1, 10'd0, 8'h00, 2'b00});
        @(posedge clk);
        @(negedge clk);
        check("reinit_addr1", {init_done, mem_wen, mem_waddr, mem_data_in, req_ready},
                              {1'b0, 1'b1, 10'd1, 8'h00, 2'b00});
        repeat (2) @(posedge clk);
        #1;
        check("resp_queue_empty", exp_q.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
